// File: rtl/display_pkg.sv
// Shared scan-state encodings and 7-segment glyphs for the BCD display path.
// Pure definitions, no latency or flow control.
package display_pkg;

   typedef enum logic [1:0] {
      S_UNITS   = 2'd0,
      S_GUARD_U = 2'd1,
      S_TENS    = 2'd2,
      S_GUARD_T = 2'd3
   } scan_state_t;

   // Active-high glyphs, bit order {a,b,c,d,e,f,g}
   localparam logic [6:0] SEG_0   = 7'h7E;
   localparam logic [6:0] SEG_1   = 7'h30;
   localparam logic [6:0] SEG_2   = 7'h6D;
   localparam logic [6:0] SEG_3   = 7'h79;
   localparam logic [6:0] SEG_4   = 7'h33;
   localparam logic [6:0] SEG_5   = 7'h5B;
   localparam logic [6:0] SEG_6   = 7'h5F;
   localparam logic [6:0] SEG_7   = 7'h70;
   localparam logic [6:0] SEG_8   = 7'h7F;
   localparam logic [6:0] SEG_9   = 7'h7B;
   localparam logic [6:0] SEG_E   = 7'h4F;
   localparam logic [6:0] SEG_OFF = 7'h00;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to active-high 7-segment glyph; zero latency.
// No flow control; non-BCD codes render as 'E'.
module bcd_to_7seg
   import display_pkg::*;
(
   input  logic [3:0] i_digit,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = SEG_E;
      case (i_digit)
         4'd0:    o_seg = SEG_0;
         4'd1:    o_seg = SEG_1;
         4'd2:    o_seg = SEG_2;
         4'd3:    o_seg = SEG_3;
         4'd4:    o_seg = SEG_4;
         4'd5:    o_seg = SEG_5;
         4'd6:    o_seg = SEG_6;
         4'd7:    o_seg = SEG_7;
         4'd8:    o_seg = SEG_8;
         4'd9:    o_seg = SEG_9;
         default: o_seg = SEG_E;
      endcase
   end

endmodule

// File: rtl/display_bcd_2dig_mux.sv
// Two-digit multiplexed 7-segment driver; outputs registered, one cycle behind the scan state.
// Free-running scan with no backpressure; digits captured once per frame to avoid tearing.
module display_bcd_2dig_mux
   import display_pkg::*;
#(
   parameter int REFRESH_DIV    = 50000,
   parameter int GUARD_CYC      = 16,
   parameter int BLINK_FRAMES   = 25,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit DIG_ACTIVE_LOW = 1'b1
)(
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] units,
   input  logic [3:0] tens,
   input  logic       blank_lz,
   input  logic       blink_en,
   output logic [6:0] seg,
   output logic       dp,
   output logic [1:0] dig,
   output logic       err
);

   localparam int CNT_W = ($clog2(max2(REFRESH_DIV, GUARD_CYC)) < 1) ? 1
                        : $clog2(max2(REFRESH_DIV, GUARD_CYC));
   localparam int FRM_W = ($clog2(BLINK_FRAMES + 1) < 1) ? 1 : $clog2(BLINK_FRAMES + 1);

   localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] GUARD_LAST   = CNT_W'(GUARD_CYC - 1);
   localparam logic [FRM_W-1:0] FRM_LAST     = FRM_W'(BLINK_FRAMES - 1);

   localparam logic [6:0] SEG_UNLIT = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic       DP_UNLIT  = SEG_ACTIVE_LOW;
   localparam logic [1:0] DIG_IDLE  = DIG_ACTIVE_LOW ? 2'b11 : 2'b00;

   scan_state_t      r_state;
   scan_state_t      w_next_state;
   logic [CNT_W-1:0] r_cnt;
   logic [3:0]       r_units;
   logic [3:0]       r_tens;
   logic             r_err;
   logic             r_phase_on;
   logic [FRM_W-1:0] r_frm;
   logic [6:0]       r_seg;
   logic             r_dp;
   logic [1:0]       r_dig;

   logic             w_lit_slot;
   logic             w_last;
   logic             w_capture;
   logic             w_lit_ok;
   logic             w_show_u;
   logic             w_show_t;
   logic [3:0]       w_sel_digit;
   logic [6:0]       w_glyph;
   logic [6:0]       w_seg_act;
   logic [1:0]       w_dig_act;

   assign w_lit_slot = (r_state == S_UNITS) || (r_state == S_TENS);
   assign w_last     = w_lit_slot ? (r_cnt == REFRESH_LAST) : (r_cnt == GUARD_LAST);
   assign w_capture  = (r_state == S_GUARD_T) && w_last;

   always_comb begin
      w_next_state = S_UNITS;
      case (r_state)
         S_UNITS:   w_next_state = S_GUARD_U;
         S_GUARD_U: w_next_state = S_TENS;
         S_TENS:    w_next_state = S_GUARD_T;
         S_GUARD_T: w_next_state = S_UNITS;
         default:   w_next_state = S_UNITS;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= S_UNITS;
         r_cnt   <= '0;
      end else if (w_last) begin
         r_state <= w_next_state;
         r_cnt   <= '0;
      end else begin
         r_cnt   <= r_cnt + 1'b1;
      end
   end

   // Digits and error flag only move at the frame boundary so a frame never mixes old and new values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_units <= '0;
         r_tens  <= '0;
         r_err   <= 1'b0;
      end else if (w_capture) begin
         r_units <= units;
         r_tens  <= tens;
         r_err   <= (units > 4'd9) || (tens > 4'd9);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_phase_on <= 1'b1;
         r_frm      <= '0;
      end else if (!blink_en) begin
         r_phase_on <= 1'b1;
         r_frm      <= '0;
      end else if (w_capture) begin
         if (r_frm == FRM_LAST) begin
            r_phase_on <= ~r_phase_on;
            r_frm      <= '0;
         end else begin
            r_frm      <= r_frm + 1'b1;
         end
      end
   end

   assign w_sel_digit = (r_state == S_TENS) ? r_tens : r_units;

   bcd_to_7seg u_dec (
      .i_digit (w_sel_digit),
      .o_seg   (w_glyph)
   );

   // blink_en is used live so dropping it re-lights the display on the very next edge.
   assign w_lit_ok  = !blink_en || r_phase_on;
   assign w_show_u  = (r_state == S_UNITS) && w_lit_ok;
   assign w_show_t  = (r_state == S_TENS) && w_lit_ok && !(blank_lz && (r_tens == 4'd0));
   assign w_dig_act = {w_show_t, w_show_u};
   assign w_seg_act = (w_show_t || w_show_u) ? w_glyph : SEG_OFF;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_seg <= SEG_UNLIT;
         r_dp  <= DP_UNLIT;
         r_dig <= DIG_IDLE;
      end else begin
         r_seg <= SEG_ACTIVE_LOW ? ~w_seg_act : w_seg_act;
         r_dp  <= DP_UNLIT;
         r_dig <= DIG_ACTIVE_LOW ? ~w_dig_act : w_dig_act;
      end
   end

   assign seg = r_seg;
   assign dp  = r_dp;
   assign dig = r_dig;
   assign err = r_err;

endmodule

// File: tb/tb_display_bcd_2dig_mux.sv
// Randomised frame stimulus against a frame-level display model, scoreboarded per lit slot.
module tb_display_bcd_2dig_mux;

   localparam int RD    = 4;
   localparam int GC    = 1;
   localparam int BF    = 2;
   localparam int FRAME = 2 * (RD + GC);
   localparam int ND    = 12;
   localparam int NF    = 52;

   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] units;
   logic [3:0] tens;
   logic       blank_lz;
   logic       blink_en;
   logic [6:0] seg;
   logic       dp;
   logic [1:0] dig;
   logic       err;

   always #5 clock = ~clock;

   display_bcd_2dig_mux #(
      .REFRESH_DIV    (RD),
      .GUARD_CYC      (GC),
      .BLINK_FRAMES   (BF),
      .SEG_ACTIVE_LOW (1'b1),
      .DIG_ACTIVE_LOW (1'b1)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .units    (units),
      .tens     (tens),
      .blank_lz (blank_lz),
      .blink_en (blink_en),
      .seg      (seg),
      .dp       (dp),
      .dig      (dig),
      .err      (err)
   );

   typedef struct packed {
      logic [1:0] dig;
      logic [6:0] seg;
      logic       err;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;
   int   edge_n = 0;
   bit   mon_on = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic [6:0] glyph(input int v);
      case (v)
         0: return 7'h7E;  1: return 7'h30;  2: return 7'h6D;  3: return 7'h79;
         4: return 7'h33;  5: return 7'h5B;  6: return 7'h5F;  7: return 7'h70;
         8: return 7'h7F;  9: return 7'h7B;
         default: return 7'h4F;
      endcase
   endfunction

   // Expected dig for output cycle e (edges counted from reset release), plain scan arithmetic.
   function automatic logic [1:0] scan_dig(input int e);
      int p;
      p = (e - 1) % FRAME;
      if (p < RD)          return 2'b10;
      if (p == RD)         return 2'b11;
      if (p < 2 * RD + GC) return 2'b01;
      return 2'b11;
   endfunction

   always @(posedge clock) if (reset === 1'b1) edge_n++;

   logic [1:0] prev_dig = 2'b11;
   int         run_len  = 0;
   exp_t       got;
   exp_t       want;

   always @(negedge clock) begin
      if (!mon_on) begin
         prev_dig = 2'b11;
         run_len  = 0;
      end else begin
         if (edge_n >= 1 && edge_n <= 3 * FRAME)
            check("scan_timing", 32'(dig), 32'(scan_dig(edge_n)));
         if (prev_dig != 2'b11 && dig != prev_dig)
            check("slot_length", 32'(run_len), 32'(RD));
         if (dig != 2'b11) begin
            if (dig != prev_dig) begin
               run_len = 1;
               got = '{dig: dig, seg: seg, err: err};
               if (q.size() == 0) begin
                  check("unexpected_lit_slot", 32'(got), 32'h0);
               end else begin
                  want = q.pop_front();
                  check("slot_dig", 32'(got.dig), 32'(want.dig));
                  check("slot_seg", 32'(got.seg), 32'(want.seg));
                  check("slot_err", 32'(got.err), 32'(want.err));
                  check("slot_dp",  32'(dp), 32'h1);
               end
            end else begin
               run_len++;
            end
         end else begin
            run_len = 0;
         end
         prev_dig = dig;
      end
   end

   // Directed frames: {units, tens, mid-frame units, mid-frame tens, blank_lz, blink_en}
   int tbl_u  [ND] = '{7, 4, 4, 8, 8, 12, 2, 2, 3, 3, 3, 5};
   int tbl_t  [ND] = '{3, 2, 2, 0, 0,  1, 1, 1, 4, 4, 4, 0};
   int tbl_u2 [ND] = '{7, 4, 5, 8, 8, 12, 2, 2, 3, 3, 3, 5};
   int tbl_t2 [ND] = '{3, 2, 2, 0, 0,  1, 1, 1, 4, 4, 4, 0};
   bit tbl_bl [ND] = '{0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1, 0};
   bit tbl_bk [ND] = '{0, 0, 0, 0, 0,  0, 0, 1, 1, 1, 1, 0};

   initial begin
      int  hu, ht, run, du, dt, du2, dt2;
      bit  bl, bk, prev_bk, on, lit, e;
      int  waited;

      hu = 0; ht = 0; run = 0; prev_bk = 1'b0;
      units = 4'd7; tens = 4'd3; blank_lz = 1'b0; blink_en = 1'b0;
      reset = 1'b1;
      #1 reset = 1'b0;
      #11;
      check("reset_dig", 32'(dig), 32'h3);
      check("reset_seg", 32'(seg), 32'h7F);
      check("reset_err", 32'(err), 32'h0);
      check("reset_dp",  32'(dp),  32'h1);

      @(negedge clock);
      mon_on = 1'b1;
      for (int m = 0; m < NF; m++) begin
         if (m < ND) begin
            du = tbl_u[m]; dt = tbl_t[m]; du2 = tbl_u2[m]; dt2 = tbl_t2[m];
            bl = tbl_bl[m]; bk = tbl_bk[m];
         end else begin
            du  = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
            dt  = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 15);
            du2 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : du;
            dt2 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : dt;
            bl  = 1'($urandom_range(0, 1));
            bk  = ($urandom_range(0, 3) == 0) ? !prev_bk : prev_bk;
         end
         units = 4'(du); tens = 4'(dt); blank_lz = bl; blink_en = bk;
         if (m == 0) reset = 1'b1;

         // Blink phase from the length of the unbroken run of enabled frame boundaries.
         if (m > 0) run = prev_bk ? run + 1 : 0;
         on  = ((run / BF) % 2) == 0;
         lit = !bk || on;
         e   = (hu > 9) || (ht > 9);
         if (lit) q.push_back('{dig: 2'b10, seg: ~glyph(hu), err: e});
         if (lit && !(bl && ht == 0)) q.push_back('{dig: 2'b01, seg: ~glyph(ht), err: e});

         repeat (6) @(negedge clock);
         units = 4'(du2); tens = 4'(dt2);
         repeat (FRAME - 6) @(negedge clock);
         hu = du2; ht = dt2; prev_bk = bk;
      end

      mon_on = 1'b0;
      check("scoreboard_drained", 32'(q.size()), 32'h0);
      blink_en = 1'b0;
      blank_lz = 1'b0;

      waited = 0;
      while (dig != 2'b01 && waited < 4 * FRAME) begin
         @(negedge clock);
         waited++;
      end
      check("tens_slot_reached", 32'(dig), 32'h1);
      #2 reset = 1'b0;
      #1;
      check("async_reset_dig", 32'(dig), 32'h3);
      check("async_reset_seg", 32'(seg), 32'h7F);
      check("async_reset_err", 32'(err), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
